// File: rtl/l2_trigger_sequencer_if.sv
// Handshake bundle for l2_trigger_sequencer: event input side and result output side.
// master = event source / result sink, slave = the sequencer.
interface l2_trigger_sequencer_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] n1;
    logic signed [15:0] n2;
    logic signed [15:0] n3;
    logic               out_valid;
    logic               out_ready;
    logic               trigger;
    logic signed [31:0] score;
    logic [15:0]        trig_count;

    modport master (
        output in_valid, n1, n2, n3, out_ready,
        input  in_ready, out_valid, trigger, score, trig_count
    );

    modport slave (
        input  in_valid, n1, n2, n3, out_ready,
        output in_ready, out_valid, trigger, score, trig_count
    );
endinterface

// File: rtl/l2_trigger_sequencer.sv
// Serial L2 output layer: score = sum((n_i*w_i)>>>7) + b on one shared 16x8 multiplier,
// thresholded and presented on valid/ready. Macro L2_DEADTIME_EN adds post-trigger deadtime.
//
// state | meaning
// IDLE  | ready for an event (in_ready=1)
// MAC   | three multiply-accumulate steps, one neuron per cycle
// OUT   | result held on out_valid until consumed
// DEAD  | readout busy after a consumed trigger (L2_DEADTIME_EN only)
module l2_trigger_sequencer #(
    parameter logic signed [31:0] THRESH   = 32'sd0,
    parameter int                 DEADTIME = 4,
    parameter logic signed [7:0]  L2_W1    = 8'sd50,
    parameter logic signed [7:0]  L2_W2    = -8'sd30,
    parameter logic signed [7:0]  L2_W3    = 8'sd17,
    parameter logic signed [7:0]  L2_B     = -8'sd5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    l2_trigger_sequencer_if.slave   l2_if
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_OUT
`ifdef L2_DEADTIME_EN
        , S_DEAD
`endif
    } state_t;

    if (DEADTIME < 0 || DEADTIME > 255) begin : g_bad_deadtime
        $error("l2_trigger_sequencer: DEADTIME must be within 0..255");
    end

    state_t             state_q;
    logic [1:0]         step_q;
    logic signed [15:0] n1_q, n2_q, n3_q;
    logic signed [31:0] acc_q;
    logic signed [31:0] acc_d;
    logic signed [31:0] score_q;
    logic               trigger_q;
    logic               out_valid_q;
    logic [15:0]        trig_cnt_q;
`ifdef L2_DEADTIME_EN
    logic [7:0]         dead_q;
`endif

    logic signed [15:0] n_sel;
    logic signed [7:0]  w_sel;
    logic signed [23:0] prod;

    // Operand mux for the single multiplier; shift floors each term before the add.
    always_comb begin
        n_sel = n3_q;
        w_sel = L2_W3;
        case (step_q)
            2'd0: begin
                n_sel = n1_q;
                w_sel = L2_W1;
            end
            2'd1: begin
                n_sel = n2_q;
                w_sel = L2_W2;
            end
            default: begin
                n_sel = n3_q;
                w_sel = L2_W3;
            end
        endcase
        prod  = 24'(n_sel) * 24'(w_sel);
        acc_d = acc_q + 32'(prod >>> 7);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            step_q      <= 2'd0;
            n1_q        <= '0;
            n2_q        <= '0;
            n3_q        <= '0;
            acc_q       <= '0;
            score_q     <= '0;
            trigger_q   <= 1'b0;
            out_valid_q <= 1'b0;
            trig_cnt_q  <= '0;
`ifdef L2_DEADTIME_EN
            dead_q      <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (l2_if.in_valid) begin
                        n1_q    <= l2_if.n1;
                        n2_q    <= l2_if.n2;
                        n3_q    <= l2_if.n3;
                        acc_q   <= 32'(L2_B);
                        step_q  <= 2'd0;
                        state_q <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc_q <= acc_d;
                    if (step_q == 2'd2) begin
                        score_q     <= acc_d;
                        trigger_q   <= (acc_d > THRESH);
                        out_valid_q <= 1'b1;
                        step_q      <= 2'd0;
                        state_q     <= S_OUT;
                    end else begin
                        step_q <= step_q + 2'd1;
                    end
                end
                S_OUT: begin
                    if (l2_if.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (trigger_q && (trig_cnt_q != 16'hFFFF)) begin
                            trig_cnt_q <= trig_cnt_q + 16'd1;
                        end
`ifdef L2_DEADTIME_EN
                        if (trigger_q && (DEADTIME > 0)) begin
                            dead_q  <= 8'(DEADTIME);
                            state_q <= S_DEAD;
                        end else begin
                            state_q <= S_IDLE;
                        end
`else
                        state_q <= S_IDLE;
`endif
                    end
                end
`ifdef L2_DEADTIME_EN
                S_DEAD: begin
                    dead_q <= dead_q - 8'd1;
                    if (dead_q == 8'd1) begin
                        state_q <= S_IDLE;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign l2_if.in_ready   = (state_q == S_IDLE);
    assign l2_if.out_valid  = out_valid_q;
    assign l2_if.trigger    = trigger_q;
    assign l2_if.score      = score_q;
    assign l2_if.trig_count = trig_cnt_q;

endmodule

// File: tb/tb_l2_trigger_sequencer.sv
// Bench for l2_trigger_sequencer: timeline model of ready/valid windows plus a floor-division
// score model, checked every cycle, with directed literal expectations.
module tb_l2_trigger_sequencer;
    localparam logic signed [31:0] THR = 32'sd0;
    localparam int                 DT  = 4;
    localparam logic signed [7:0]  TW1 = 8'sd50;
    localparam logic signed [7:0]  TW2 = -8'sd30;
    localparam logic signed [7:0]  TW3 = 8'sd17;
    localparam logic signed [7:0]  TB  = -8'sd5;
`ifdef L2_DEADTIME_EN
    localparam bit DEAD_ON = 1'b1;
`else
    localparam bit DEAD_ON = 1'b0;
`endif
    localparam int DT_EXP = DEAD_ON ? DT : 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    l2_trigger_sequencer_if bus ();

    l2_trigger_sequencer #(
        .THRESH   (THR),
        .DEADTIME (DT),
        .L2_W1    (TW1),
        .L2_W2    (TW2),
        .L2_W3    (TW3),
        .L2_B     (TB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .l2_if (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int fdiv128(input int t);
        int r;
        r = t % 128;
        if (r < 0) r += 128;
        return (t - r) / 128;
    endfunction

    function automatic int l2_score(input int a, input int b, input int c);
        return int'(TB) + fdiv128(a * int'(TW1)) + fdiv128(b * int'(TW2)) + fdiv128(c * int'(TW3));
    endfunction

    // Model: edge indices at which the block becomes free / the result appears.
    int  cyc, m_free_at, m_out_at, m_score, m_next, m_cnt;
    bit  m_pend, m_trig;
    int  exp_q[$];
    int  n_acc, n_cons, n_trig_seen;
    bit  cmp_en = 1'b0;
    bit  rand_mode = 1'b0;
    bit  m_rdy, m_ovl;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; m_free_at = 0; m_out_at = 0; m_score = 0; m_next = 0; m_cnt = 0;
            m_pend = 1'b0; m_trig = 1'b0;
            exp_q.delete();
            n_acc = 0; n_cons = 0; n_trig_seen = 0;
        end else begin
            m_rdy = !m_pend && (cyc >= m_free_at);
            m_ovl = m_pend && (cyc >= m_out_at);
            cyc++;
            if (m_ovl && bus.out_ready) begin
                m_pend = 1'b0;
                if (m_trig && m_cnt != 65535) m_cnt++;
                m_free_at = cyc + ((m_trig && DEAD_ON) ? DT : 0);
            end
            if (m_rdy && bus.in_valid) begin
                m_pend   = 1'b1;
                m_out_at = cyc + 3;
                m_next   = l2_score(int'(bus.n1), int'(bus.n2), int'(bus.n3));
                exp_q.push_back(m_next);
                n_acc++;
            end
            if (m_pend && cyc == m_out_at) begin
                m_score = m_next;
                m_trig  = (m_next > int'(THR));
            end
        end
    end

    always @(negedge clk) begin
        int e;
        #1;
        if (cmp_en) begin
            chk("in_ready",   bus.in_ready,   longint'(!m_pend && (cyc >= m_free_at)));
            chk("out_valid",  bus.out_valid,  longint'(m_pend && (cyc >= m_out_at)));
            chk("score",      longint'(bus.score), m_score);
            chk("trigger",    bus.trigger,    m_trig);
            chk("trig_count", bus.trig_count, m_cnt);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                chk("queue_depth", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("in_order_score", longint'(bus.score), e);
                    n_cons++;
                    if (e > int'(THR)) n_trig_seen++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rand_mode) bus.out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic signed [15:0] a, input logic signed [15:0] b,
                        input logic signed [15:0] c);
        bit ok;
        int k;
        bus.n1 = a; bus.n2 = b; bus.n3 = c;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        k = 0;
        while (!ok && k < 200) begin
            ok = bus.in_ready;
            @(negedge clk);
            k++;
        end
        chk("accept_timeout", ok, 1);
    endtask

    task automatic wait_ov();
        int k;
        k = 0;
        while (!bus.out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("out_valid_timeout", bus.out_valid, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, dl, ovc;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.n1 = '0; bus.n2 = '0; bus.n3 = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_score",     longint'(bus.score), 0);
        chk("rst_trigger",   bus.trigger, 0);
        chk("rst_trig_cnt",  bus.trig_count, 0);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // single term, latency, input sampling only at accept
        send(16'sd128, 16'sd0, 16'sd0);
        bus.in_valid = 1'b0;
        bus.n1 = 16'sd999; bus.n2 = -16'sd999; bus.n3 = 16'sd777;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("single_latency", lat, 3);
        chk("single_score",   longint'(bus.score), 45);
        chk("single_trigger", bus.trigger, 1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("single_trig_cnt", bus.trig_count, 1);
        chk("single_consumed", bus.out_valid, 0);
        dl = 0;
        while (!bus.in_ready && dl < 20) begin
            dl++;
            @(negedge clk);
        end
        chk("deadtime_cycles", dl, DT_EXP);

        // floor rounding of a negative term
        send(-16'sd1, 16'sd0, 16'sd0);
        bus.in_valid = 1'b0;
        wait_ov();
        chk("floor_score",   longint'(bus.score), -6);
        chk("floor_trigger", bus.trigger, 0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("no_dead_after_noise", bus.in_ready, 1);
        chk("floor_trig_cnt",      bus.trig_count, 1);

        // backpressure with a second event waiting
        send(16'sd256, 16'sd128, -16'sd128);
        bus.n1 = 16'sd128; bus.n2 = 16'sd0; bus.n3 = 16'sd0;
        wait_ov();
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_score",     longint'(bus.score), 48);
            chk("bp_trigger",   bus.trigger, 1);
            chk("bp_in_ready",  bus.in_ready, 0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        send(16'sd128, 16'sd0, 16'sd0);
        bus.in_valid = 1'b0;
        chk("bp_trig_cnt", bus.trig_count, 2);
        wait_ov();
        chk("bp_second_score", longint'(bus.score), 45);
        @(negedge clk);
        chk("bp_trig_cnt2", bus.trig_count, 3);

        // asynchronous reset in the middle of MAC
        send(16'sd128, 16'sd128, 16'sd128);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("amid_in_ready",  bus.in_ready, 1);
        chk("amid_out_valid", bus.out_valid, 0);
        chk("amid_score",     longint'(bus.score), 0);
        chk("amid_trigger",   bus.trigger, 0);
        chk("amid_trig_cnt",  bus.trig_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ovc = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) ovc++;
        end
        chk("amid_no_result", ovc, 0);

        // random back-to-back events with random backpressure
        rand_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            send(16'($urandom), 16'($urandom), 16'($urandom));
        end
        bus.in_valid = 1'b0;
        rand_mode = 1'b0;
        bus.out_ready = 1'b1;
        repeat (20) @(negedge clk);
        chk("rand_accepted",  n_acc, 1000);
        chk("rand_consumed",  n_cons, 1000);
        chk("rand_leftover",  exp_q.size(), 0);
        chk("rand_trig_cnt",  bus.trig_count, n_trig_seen);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
